// File: rtl/chart_sequencer_if.sv
// chart_sequencer_if: chart RAM, beat strobe and lane launch signals of the chart sequencer
interface chart_sequencer_if #(
  parameter int ADDRW = 8
);
  logic             start;
  logic             pause;
  logic             quarter;
  logic             eigth;
  logic             sixteenth;
  logic [7:0]       rd_data;
  logic [ADDRW-1:0] rd_addr;
  logic [3:0]       launch;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] lines;
  modport master (
    output start, pause, quarter, eigth, sixteenth, rd_data,
    input  rd_addr, launch, busy, done, lines
  );
  modport slave (
    input  start, pause, quarter, eigth, sixteenth, rd_data,
    output rd_addr, launch, busy, done, lines
  );
endinterface

// File: rtl/chart_sequencer.sv
// chart_sequencer: steps through chart lines, waits for each line's beat strobe, pulses the arrow lanes
module chart_sequencer #(
  parameter int ADDRW = 8,
  parameter int DEPTH = 256
) (
  input logic             clk_i,
  input logic             reset_i,
  chart_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, WAIT_BEAT, LAUNCH, DONE} state_t;
  state_t           state, next;
  logic [3:0]       line_arrows, line_timing;
  logic [ADDRW-1:0] rd_addr, lines;
  logic             beat, last, idle;
  always_comb begin
    idle = (state == IDLE) || (state == DONE);
    last = rd_addr == ADDRW'(DEPTH - 1);
    beat = (line_timing == 4'hF) ? bus.sixteenth : line_timing[3] ? bus.eigth : bus.quarter;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      rd_addr     <= '0;
      lines       <= '0;
      line_arrows <= '0;
      line_timing <= '0;
    end else begin
      state <= next;
      if (idle && bus.start) begin
        rd_addr <= '0;
        lines   <= '0;
      end
      if (state == LATCH) {line_arrows, line_timing} <= bus.rd_data;
      if (state == LAUNCH) begin
        if (!last) rd_addr <= rd_addr + 1'b1;
        if (!(&lines)) lines <= lines + 1'b1;
      end
    end
  end
  // the line being decoded in LATCH is still on rd_data, not yet in line_timing
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = bus.start ? FETCH : state;
      FETCH:      next = LATCH;
      LATCH:      next = (bus.rd_data[3:0] == 4'h0) ? DONE :
                         (bus.rd_data[3:2] == 2'b00) ? LAUNCH : WAIT_BEAT;
      WAIT_BEAT:  next = (beat && !bus.pause) ? LAUNCH : WAIT_BEAT;
      LAUNCH:     next = last ? DONE : FETCH;
      default:    next = IDLE;
    endcase
  end
  always_comb begin
    bus.launch  = (state == LAUNCH && line_timing[3:2] != 2'b00) ? line_arrows : 4'h0;
    bus.busy    = !idle;
    bus.done    = state == DONE;
    bus.rd_addr = rd_addr;
    bus.lines   = lines;
  end
endmodule

// File: tb/tb_chart_sequencer.sv
// tb_chart_sequencer: directed playback scenarios on a 4-line chart with a 2-bit line counter
module tb_chart_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors = 0;
  logic [7:0] ram [4];
  chart_sequencer_if #(.ADDRW(2)) bus ();
  chart_sequencer #(.ADDRW(2), .DEPTH(4)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic strobe_q();
    bus.quarter = 1'b1;
    tick();
    bus.quarter = 1'b0;
  endtask
  task automatic start_song();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_addr", 8'(bus.rd_addr), 8'd0);
    chk("start_lines", 8'(bus.lines), 8'd0);
    chk("start_busy", 8'(bus.busy), 8'd1);
    tick();
    tick();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.quarter = 1'b0;
    bus.eigth = 1'b0;
    bus.sixteenth = 1'b0;
    ram = '{8'h94, 8'h00, 8'h00, 8'h00};
    tick();
    tick();
    chk("rst_launch", 8'(bus.launch), 8'h0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_addr", 8'(bus.rd_addr), 8'd0);
    chk("rst_lines", 8'(bus.lines), 8'd0);
    reset = 1'b0;
    start_song();
    chk("t1_wait", 8'(bus.launch), 8'h0);
    strobe_q();
    chk("t1_launch", 8'(bus.launch), 8'h9);
    tick();
    chk("t1_after", 8'(bus.launch), 8'h0);
    chk("t1_addr", 8'(bus.rd_addr), 8'd1);
    chk("t1_lines", 8'(bus.lines), 8'd1);
    tick();
    tick();
    chk("t1_done", 8'(bus.done), 8'd1);
    chk("t1_busy", 8'(bus.busy), 8'd0);
    ram[0] = 8'h28;
    start_song();
    for (int i = 0; i < 3; i++) begin
      strobe_q();
      chk("t2_q_only", 8'(bus.launch), 8'h0);
    end
    bus.sixteenth = 1'b1;
    tick();
    bus.sixteenth = 1'b0;
    chk("t2_16_only", 8'(bus.launch), 8'h0);
    bus.eigth = 1'b1;
    bus.quarter = 1'b1;
    tick();
    bus.eigth = 1'b0;
    bus.quarter = 1'b0;
    chk("t2_launch", 8'(bus.launch), 8'h2);
    tick();
    tick();
    tick();
    chk("t2_done", 8'(bus.done), 8'd1);
    chk("t2_lines", 8'(bus.lines), 8'd1);
    ram = '{8'h4F, 8'h04, 8'h00, 8'h00};
    start_song();
    bus.sixteenth = 1'b1;
    tick();
    bus.sixteenth = 1'b0;
    chk("t4_up", 8'(bus.launch), 8'h4);
    tick();
    tick();
    tick();
    strobe_q();
    chk("t4_rest", 8'(bus.launch), 8'h0);
    chk("t4_rest_busy", 8'(bus.busy), 8'd1);
    tick();
    chk("t4_rest_lines", 8'(bus.lines), 8'd2);
    tick();
    tick();
    chk("t4_done", 8'(bus.done), 8'd1);
    chk("t4_lines", 8'(bus.lines), 8'd2);
    chk("t4_addr", 8'(bus.rd_addr), 8'd2);
    ram = '{8'h14, 8'h00, 8'h00, 8'h00};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.quarter = 1'b1;
    tick();
    bus.quarter = 1'b0;
    tick();
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe_q();
      chk("t5_paused", 8'(bus.launch), 8'h0);
      tick();
    end
    bus.pause = 1'b0;
    tick();
    chk("t5_not_queued", 8'(bus.launch), 8'h0);
    strobe_q();
    chk("t5_launch", 8'(bus.launch), 8'h1);
    tick();
    tick();
    tick();
    chk("t5_done", 8'(bus.done), 8'd1);
    ram = '{8'hF4, 8'hF4, 8'hF4, 8'hF4};
    start_song();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t6_start_busy_addr", 8'(bus.rd_addr), 8'd1);
        chk("t6_start_busy", 8'(bus.busy), 8'd1);
      end
      strobe_q();
      chk("t6_launch", 8'(bus.launch), 8'hF);
      chk("t6_addr", 8'(bus.rd_addr), 8'(i));
      tick();
      if (i < 3) begin
        tick();
        tick();
      end
    end
    chk("t6_done", 8'(bus.done), 8'd1);
    chk("t6_addr_end", 8'(bus.rd_addr), 8'd3);
    chk("t6_lines_sat", 8'(bus.lines), 8'd3);
    ram = '{8'hF2, 8'h00, 8'h00, 8'h00};
    start_song();
    chk("skip_launch", 8'(bus.launch), 8'h0);
    chk("skip_busy", 8'(bus.busy), 8'd1);
    tick();
    chk("skip_lines", 8'(bus.lines), 8'd1);
    chk("skip_addr", 8'(bus.rd_addr), 8'd1);
    tick();
    tick();
    chk("skip_done", 8'(bus.done), 8'd1);
    ram = '{8'h94, 8'h94, 8'h00, 8'h00};
    start_song();
    strobe_q();
    tick();
    tick();
    tick();
    chk("t7_wait_addr", 8'(bus.rd_addr), 8'd1);
    reset = 1'b1;
    bus.quarter = 1'b1;
    tick();
    reset = 1'b0;
    bus.quarter = 1'b0;
    chk("t7_launch", 8'(bus.launch), 8'h0);
    chk("t7_busy", 8'(bus.busy), 8'd0);
    chk("t7_done", 8'(bus.done), 8'd0);
    chk("t7_addr", 8'(bus.rd_addr), 8'd0);
    chk("t7_lines", 8'(bus.lines), 8'd0);
    tick();
    chk("t7_idle", 8'(bus.launch), 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
